// File: rtl/adma2_pkg.sv
// ADMA2 descriptor engine shared definitions.
// Holds the walker state encoding, descriptor Act codes, descriptor
// field bit positions and the codes reported on adma_error_state.
package adma2_pkg;

  // ST_STOP/ST_FDS/ST_TFR reuse the adma_error_state code points.
  typedef enum logic [1:0] {
    ST_STOP = 2'b00,
    ST_FDS  = 2'b01,
    ST_CADR = 2'b10,
    ST_TFR  = 2'b11
  } state_e;

  typedef enum logic [1:0] {
    ACT_NOP  = 2'b00,
    ACT_RSV  = 2'b01,  // reserved, behaves as nop
    ACT_TRAN = 2'b10,
    ACT_LINK = 2'b11
  } act_e;

  typedef enum logic [1:0] {
    ERR_ST_STOP = 2'b00,
    ERR_ST_FDS  = 2'b01,
    ERR_ST_TFR  = 2'b11
  } err_state_e;

  // Descriptor word layout.
  localparam int DESC_VALID_BIT = 0;
  localparam int DESC_END_BIT   = 1;
  localparam int DESC_INT_BIT   = 2;
  localparam int DESC_ACT_LSB   = 4;
  localparam int DESC_ACT_MSB   = 5;
  localparam int DESC_LEN_LSB   = 16;
  localparam int DESC_LEN_MSB   = 31;
  localparam int DESC_ADDR_LSB  = 32;
  localparam int DESC_ADDR_MSB  = 63;

endpackage

// File: rtl/adma2_descriptor_engine_if.sv
// Bus bundle between the ADMA2 descriptor engine and its environment.
//   descriptor fetch : mem_req, mem_addr -> / <- mem_ack, mem_rdata, mem_err
//   data mover       : xfer_start, xfer_addr, xfer_len -> / <- xfer_done
//   event requests   : DMA_Interrupt, ADMA_Error, Transfer_complete,
//                      ADMA_System_Address_Register -> / <- matching ack_*
// master = engine side, slave = memory / data mover / host controller side.
interface adma2_descriptor_engine_if #(
  parameter int ADDR_W = 64,
  parameter int LEN_W  = 17
);
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_ack;
  logic [63:0]       mem_rdata;
  logic              mem_err;

  logic              xfer_start;
  logic [ADDR_W-1:0] xfer_addr;
  logic [LEN_W-1:0]  xfer_len;
  logic              xfer_done;

  logic DMA_Interrupt,                ack_DMA_Interrupt;
  logic ADMA_Error,                   ack_ADMA_Error;
  logic Transfer_complete,            ack_Transfer_complete;
  logic ADMA_System_Address_Register, ack_ADMA_System_Address_Register;

  modport master (
    output mem_req, mem_addr, xfer_start, xfer_addr, xfer_len,
           DMA_Interrupt, ADMA_Error, Transfer_complete, ADMA_System_Address_Register,
    input  mem_ack, mem_rdata, mem_err, xfer_done,
           ack_DMA_Interrupt, ack_ADMA_Error, ack_Transfer_complete,
           ack_ADMA_System_Address_Register
  );

  modport slave (
    input  mem_req, mem_addr, xfer_start, xfer_addr, xfer_len,
           DMA_Interrupt, ADMA_Error, Transfer_complete, ADMA_System_Address_Register,
    output mem_ack, mem_rdata, mem_err, xfer_done,
           ack_DMA_Interrupt, ack_ADMA_Error, ack_Transfer_complete,
           ack_ADMA_System_Address_Register
  );
endinterface

// File: rtl/adma_req_hold.sv
// Sticky event request flop with set-dominant acknowledge.
//   clk, reset_n : clock, async active-low reset
//   set          : raise (or keep) the request
//   ack          : clear the request on the next edge unless set is active
//   req          : request level to the host controller
module adma_req_hold (
  input  logic clk,
  input  logic reset_n,
  input  logic set,
  input  logic ack,
  output logic req
);

  // NOTE: sequential state uses <= so every flop sees pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)  req <= 1'b0;
    else if (set)  req <= 1'b1;  // a new event beats a coincident ack
    else if (ack)  req <= 1'b0;
  end

endmodule

// File: rtl/adma2_descriptor_engine.sv
// ADMA2 master state machine: walks a descriptor table starting at
// Initial_ADMA_System_Address, hands tran descriptors to the data mover and
// raises the four sticky event requests towards the host controller.
//   clk, reset_n                : clock, async active-low reset
//   start                       : begin a walk (only honoured in ST_STOP)
//   Initial_ADMA_System_Address : table base, sampled with start
//   bus                         : fetch, data mover and event request bundle
//   adma_sys_addr               : current descriptor pointer
//   adma_error_state            : state in which the last error happened
module adma2_descriptor_engine
  import adma2_pkg::*;
#(
  parameter int ADDR_W      = 64,
  parameter int LEN_W       = 17,
  parameter int DESC_STRIDE = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] Initial_ADMA_System_Address,
  adma2_descriptor_engine_if.master bus,
  output logic [ADDR_W-1:0] adma_sys_addr,
  output logic [1:0]        adma_error_state
);

  state_e            state_q, state_d;
  act_e              act_q;
  logic              end_q, int_q;
  logic [ADDR_W-1:0] buf_addr_q;
  logic [LEN_W-1:0]  buf_len_q;

  logic        walk_start, desc_bad, fetch_ok, action_done, err_set, xfer_start;
  logic [15:0] rd_len;

  assign walk_start = (state_q == ST_STOP) && start;
  assign desc_bad   = bus.mem_err || !bus.mem_rdata[DESC_VALID_BIT];
  assign rd_len     = bus.mem_rdata[DESC_LEN_MSB:DESC_LEN_LSB];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= ST_STOP;
    else          state_q <= state_d;
  end

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    state_d     = state_q;
    fetch_ok    = 1'b0;
    err_set     = 1'b0;
    action_done = 1'b0;
    xfer_start  = 1'b0;
    case (state_q)
      ST_STOP: if (start) state_d = ST_FDS;
      ST_FDS: begin
        if (bus.mem_ack) begin
          if (desc_bad) begin
            err_set = 1'b1;
            state_d = ST_STOP;
          end else begin
            fetch_ok = 1'b1;
            state_d  = ST_CADR;
          end
        end
      end
      ST_CADR: begin
        if (act_q == ACT_TRAN) begin
          xfer_start = 1'b1;
          state_d    = ST_TFR;
        end else begin
          action_done = 1'b1;
        end
      end
      ST_TFR:  if (bus.xfer_done) action_done = 1'b1;
      default: ;
    endcase
    // A completed descriptor always moves the pointer; End stops the walk.
    if (action_done) state_d = end_q ? ST_STOP : ST_FDS;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      // NOTE: the latched descriptor is reset too, so xfer_addr/xfer_len read 0 out of reset.
      act_q            <= ACT_NOP;
      end_q            <= 1'b0;
      int_q            <= 1'b0;
      buf_addr_q       <= '0;
      buf_len_q        <= '0;
      adma_sys_addr    <= '0;
      adma_error_state <= ERR_ST_STOP;
    end else begin
      if (fetch_ok) begin
        act_q      <= act_e'(bus.mem_rdata[DESC_ACT_MSB:DESC_ACT_LSB]);
        end_q      <= bus.mem_rdata[DESC_END_BIT];
        int_q      <= bus.mem_rdata[DESC_INT_BIT];
        buf_addr_q <= ADDR_W'(bus.mem_rdata[DESC_ADDR_MSB:DESC_ADDR_LSB]);
        buf_len_q  <= (rd_len == 16'd0) ? LEN_W'(32'h1_0000) : LEN_W'(rd_len);
      end
      if (walk_start)
        adma_sys_addr <= Initial_ADMA_System_Address;
      else if (action_done)
        adma_sys_addr <= (act_q == ACT_LINK) ? buf_addr_q
                                             : adma_sys_addr + ADDR_W'(DESC_STRIDE);
      if (err_set) adma_error_state <= ERR_ST_FDS;
    end
  end

  assign bus.mem_req    = (state_q == ST_FDS);
  assign bus.mem_addr   = (state_q == ST_FDS) ? adma_sys_addr : '0;
  assign bus.xfer_start = xfer_start;
  assign bus.xfer_addr  = buf_addr_q;
  assign bus.xfer_len   = buf_len_q;

  adma_req_hold u_int_req (
    .clk(clk), .reset_n(reset_n),
    .set(action_done && int_q), .ack(bus.ack_DMA_Interrupt),
    .req(bus.DMA_Interrupt)
  );

  adma_req_hold u_err_req (
    .clk(clk), .reset_n(reset_n),
    .set(err_set), .ack(bus.ack_ADMA_Error),
    .req(bus.ADMA_Error)
  );

  adma_req_hold u_tc_req (
    .clk(clk), .reset_n(reset_n),
    .set(action_done && end_q), .ack(bus.ack_Transfer_complete),
    .req(bus.Transfer_complete)
  );

  adma_req_hold u_sar_req (
    .clk(clk), .reset_n(reset_n),
    .set(walk_start || action_done), .ack(bus.ack_ADMA_System_Address_Register),
    .req(bus.ADMA_System_Address_Register)
  );

endmodule

// File: tb/tb_adma2_descriptor_engine.sv
// Self-checking bench for adma2_descriptor_engine: directed scenarios for the
// documented corner cases, then randomized descriptor tables walked against a
// behavioural model of the descriptor rules.
module tb_adma2_descriptor_engine;
  localparam int ADDR_W = 64;
  localparam int LEN_W  = 17;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [63:0] init_addr = '0;
  logic [63:0] sys_addr;
  logic [1:0]  err_state;

  int total = 0;
  int bad   = 0;

  adma2_descriptor_engine_if #(.ADDR_W(ADDR_W), .LEN_W(LEN_W)) bus ();

  adma2_descriptor_engine #(.ADDR_W(ADDR_W), .LEN_W(LEN_W), .DESC_STRIDE(8)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .start(start),
    .Initial_ADMA_System_Address(init_addr),
    .bus(bus),
    .adma_sys_addr(sys_addr),
    .adma_error_state(err_state)
  );

  always #5 clk = ~clk;

  // Random-phase table, model expectations and observations.
  logic [63:0] tbl [logic [63:0]];
  bit          err_at [logic [63:0]];
  logic [63:0] exp_fetch[$], obs_fetch[$], exp_xa[$], obs_xa[$];
  logic [16:0] exp_xl[$], obs_xl[$];
  int          e_sar, e_int, e_tc, e_err, o_sar, o_int, o_tc, o_err;
  logic [63:0] e_ptr;
  logic [1:0]  exp_es;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_acks;
    bus.ack_DMA_Interrupt = 0;
    bus.ack_ADMA_Error = 0;
    bus.ack_Transfer_complete = 0;
    bus.ack_ADMA_System_Address_Register = 0;
  endtask

  task automatic kick(input logic [63:0] a);
    init_addr = a;
    start = 1;
    tick(1);
    start = 0;
  endtask

  task automatic feed(input logic [63:0] w, input logic e);
    bus.mem_rdata = w;
    bus.mem_err = e;
    bus.mem_ack = 1;
    tick(1);
    bus.mem_ack = 0;
    bus.mem_err = 0;
  endtask

  task automatic done_pulse;
    bus.xfer_done = 1;
    tick(1);
    bus.xfer_done = 0;
  endtask

  // 0 = DMA_Interrupt, 1 = ADMA_Error, 2 = Transfer_complete, 3 = address register
  task automatic ack(input int which);
    case (which)
      0: bus.ack_DMA_Interrupt = 1;
      1: bus.ack_ADMA_Error = 1;
      2: bus.ack_Transfer_complete = 1;
      default: bus.ack_ADMA_System_Address_Register = 1;
    endcase
    tick(1);
    clear_acks();
  endtask

  task automatic check_zero(input string p);
    check({p, " mem_req"}, bus.mem_req, 0);
    check({p, " mem_addr"}, bus.mem_addr, 0);
    check({p, " xfer_start"}, bus.xfer_start, 0);
    check({p, " xfer_addr"}, bus.xfer_addr, 0);
    check({p, " xfer_len"}, bus.xfer_len, 0);
    check({p, " int"}, bus.DMA_Interrupt, 0);
    check({p, " err"}, bus.ADMA_Error, 0);
    check({p, " tc"}, bus.Transfer_complete, 0);
    check({p, " sar"}, bus.ADMA_System_Address_Register, 0);
    check({p, " sys_addr"}, sys_addr, 0);
    check({p, " err_state"}, err_state, 0);
  endtask

  task automatic do_reset;
    reset_n = 0;
    tick(2);
    check_zero("reset");
    reset_n = 1;
    tick(1);
  endtask

  // Random table: a short chain of descriptors ending in End, an invalid
  // word or a bus error. Addresses only ever grow, so entries never collide.
  task automatic build_table(input logic [63:0] base);
    logic [63:0] cur, w;
    int n, kind, r;
    tbl.delete();
    err_at.delete();
    cur = base;
    n = $urandom_range(1, 6);
    for (int i = 0; i < n; i++) begin
      w = '0;
      w[0] = 1'b1;
      w[2] = ($urandom_range(0, 2) == 0);
      w[3] = 1'($urandom);
      w[15:6] = 10'($urandom);
      kind = $urandom_range(0, 3);
      w[5:4] = 2'(kind);
      w[31:16] = ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom);
      if (kind == 3) w[63:32] = cur[31:0] + 32'($urandom_range(1, 4) * 256);
      else           w[63:32] = $urandom;
      if (i == n - 1) begin
        r = $urandom_range(0, 3);
        if (r == 0)      w[0] = 1'b0;
        else if (r == 1) err_at[cur] = 1'b1;
        else             w[1] = 1'b1;
      end
      tbl[cur] = w;
      cur = (kind == 3) ? {32'h0, w[63:32]} : cur + 64'd8;
    end
  endtask

  // Behavioural walk of the descriptor rules.
  task automatic model_walk(input logic [63:0] init);
    logic [63:0] p, w;
    exp_fetch.delete(); exp_xa.delete(); exp_xl.delete();
    e_sar = 1; e_int = 0; e_tc = 0; e_err = 0;
    p = init;
    for (int i = 0; i < 64; i++) begin
      exp_fetch.push_back(p);
      w = tbl.exists(p) ? tbl[p] : 64'h0;
      if (err_at.exists(p) || !w[0]) begin
        e_err = 1;
        break;
      end
      if (w[5:4] == 2'b10) begin
        exp_xa.push_back({32'h0, w[63:32]});
        exp_xl.push_back((w[31:16] == 16'h0) ? 17'h10000 : {1'b0, w[31:16]});
      end
      p = (w[5:4] == 2'b11) ? {32'h0, w[63:32]} : p + 64'd8;
      e_sar++;
      if (w[2]) e_int++;
      if (w[1]) begin
        e_tc = 1;
        break;
      end
    end
    e_ptr = p;
  endtask

  // Memory, data mover and host roles with random latencies; every request
  // is acked on sight, so each observed high level is one event.
  task automatic run_walk(input logic [63:0] a);
    int mw, xw, tail;
    bit fin;
    obs_fetch.delete(); obs_xa.delete(); obs_xl.delete();
    o_sar = 0; o_int = 0; o_tc = 0; o_err = 0;
    mw = -1; xw = -1; fin = 0; tail = 0;
    init_addr = a;
    start = 1;
    for (int c = 0; c < 600 && tail < 6; c++) begin
      @(negedge clk);
      start = 0;
      bus.mem_ack = 0; bus.mem_err = 0; bus.xfer_done = 0;
      if (bus.DMA_Interrupt) o_int++;
      if (bus.ADMA_Error) o_err++;
      if (bus.Transfer_complete) o_tc++;
      if (bus.ADMA_System_Address_Register) o_sar++;
      bus.ack_DMA_Interrupt = bus.DMA_Interrupt;
      bus.ack_ADMA_Error = bus.ADMA_Error;
      bus.ack_Transfer_complete = bus.Transfer_complete;
      bus.ack_ADMA_System_Address_Register = bus.ADMA_System_Address_Register;
      if (bus.Transfer_complete || bus.ADMA_Error) fin = 1;
      if (fin) tail++;
      if (bus.xfer_start) begin
        obs_xa.push_back(bus.xfer_addr);
        obs_xl.push_back(bus.xfer_len);
        xw = $urandom_range(0, 3);
      end else if (xw == 0) begin
        bus.xfer_done = 1;
        xw = -1;
      end else if (xw > 0) begin
        xw--;
      end
      if (bus.mem_req) begin
        if (mw < 0) begin
          obs_fetch.push_back(bus.mem_addr);
          mw = $urandom_range(0, 3);
        end
        if (mw == 0) begin
          bus.mem_ack = 1;
          bus.mem_rdata = tbl.exists(bus.mem_addr) ? tbl[bus.mem_addr] : 64'h0;
          bus.mem_err = err_at.exists(bus.mem_addr);
          mw = -1;
        end else begin
          mw--;
        end
      end
      // Stray starts mid-walk must be ignored.
      if (!fin && $urandom_range(0, 15) == 0) begin
        start = 1;
        init_addr = 64'($urandom);
      end
    end
    start = 0;
    bus.mem_ack = 0; bus.mem_err = 0; bus.xfer_done = 0;
    clear_acks();
    tick(1);
    check("rnd walk ended", fin, 1);
  endtask

  initial begin
    bus.mem_ack = 0; bus.mem_rdata = '0; bus.mem_err = 0; bus.xfer_done = 0;
    clear_acks();

    // Single tran+End.
    do_reset();
    kick(64'h1000);
    check("t1 mem_req", bus.mem_req, 1);
    check("t1 mem_addr", bus.mem_addr, 64'h1000);
    check("t1 sar", bus.ADMA_System_Address_Register, 1);
    feed(64'h0000_8000_0200_0023, 0);
    check("t1 xfer_start", bus.xfer_start, 1);
    check("t1 xfer_addr", bus.xfer_addr, 64'h8000);
    check("t1 xfer_len", bus.xfer_len, 17'h200);
    tick(1);
    check("t1 xfer_start pulse", bus.xfer_start, 0);
    tick(2);
    check("t1 tc early", bus.Transfer_complete, 0);
    done_pulse();
    check("t1 tc", bus.Transfer_complete, 1);
    check("t1 sys_addr", sys_addr, 64'h1008);
    check("t1 mem_req idle", bus.mem_req, 0);
    tick(3);
    check("t1 tc held", bus.Transfer_complete, 1);
    ack(2);
    check("t1 tc acked", bus.Transfer_complete, 0);

    // Link then tran+End.
    do_reset();
    kick(64'h1000);
    check("t2 sar start", bus.ADMA_System_Address_Register, 1);
    ack(3);
    check("t2 sar acked", bus.ADMA_System_Address_Register, 0);
    check("t2 mem_addr0", bus.mem_addr, 64'h1000);
    feed(64'h0000_2000_0000_0031, 0);
    check("t2 no xfer", bus.xfer_start, 0);
    tick(1);
    check("t2 mem_addr1", bus.mem_addr, 64'h2000);
    check("t2 sys_addr link", sys_addr, 64'h2000);
    check("t2 sar link", bus.ADMA_System_Address_Register, 1);
    tick(3);
    check("t2 sar held", bus.ADMA_System_Address_Register, 1);
    ack(3);
    check("t2 sar cleared", bus.ADMA_System_Address_Register, 0);
    feed(64'h0000_8000_0200_0023, 0);
    check("t2 xfer_start", bus.xfer_start, 1);
    tick(1);
    done_pulse();
    check("t2 tc", bus.Transfer_complete, 1);
    check("t2 sys_addr end", sys_addr, 64'h2008);

    // Invalid descriptor, then bus error on a valid word.
    do_reset();
    kick(64'h3000);
    feed(64'h0, 0);
    check("t3 err", bus.ADMA_Error, 1);
    check("t3 err_state", err_state, 2'b01);
    check("t3 stopped", bus.mem_req, 0);
    check("t3 no xfer", bus.xfer_start, 0);
    check("t3 no tc", bus.Transfer_complete, 0);
    tick(2);
    check("t3 err held", bus.ADMA_Error, 1);
    check("t3 still stopped", bus.mem_req, 0);
    ack(1);
    check("t3 err acked", bus.ADMA_Error, 0);
    do_reset();
    kick(64'h3100);
    feed(64'h0000_8000_0200_0021, 1);
    check("t3b err", bus.ADMA_Error, 1);
    check("t3b err_state", err_state, 2'b01);
    check("t3b stopped", bus.mem_req, 0);
    check("t3b no xfer", bus.xfer_start, 0);
    check("t3b sys_addr", sys_addr, 64'h3100);

    // Zero length means 65536, with Int and End.
    do_reset();
    kick(64'h4000);
    feed(64'h0000_4000_0000_0027, 0);
    check("t4 xfer_start", bus.xfer_start, 1);
    check("t4 xfer_addr", bus.xfer_addr, 64'h4000);
    check("t4 xfer_len", bus.xfer_len, 17'h10000);
    tick(1);
    check("t4 int before done", bus.DMA_Interrupt, 0);
    done_pulse();
    check("t4 int", bus.DMA_Interrupt, 1);
    check("t4 tc", bus.Transfer_complete, 1);
    ack(0);
    check("t4 int acked", bus.DMA_Interrupt, 0);
    check("t4 tc kept", bus.Transfer_complete, 1);

    // Ack coinciding with a new Int event: set wins.
    do_reset();
    kick(64'h5000);
    feed(64'h5, 0);
    tick(1);
    check("t5 int first", bus.DMA_Interrupt, 1);
    check("t5 mem_addr", bus.mem_addr, 64'h5008);
    feed(64'h7, 0);
    bus.ack_DMA_Interrupt = 1;
    tick(1);
    clear_acks();
    check("t5 int set+ack", bus.DMA_Interrupt, 1);
    check("t5 tc", bus.Transfer_complete, 1);
    check("t5 sys_addr", sys_addr, 64'h5010);
    tick(1);
    check("t5 int held", bus.DMA_Interrupt, 1);
    ack(0);
    check("t5 int acked", bus.DMA_Interrupt, 0);
    ack(0);
    check("t5 ack while low", bus.DMA_Interrupt, 0);

    // Pointer wrap at the top of the address space.
    do_reset();
    kick(64'hFFFF_FFFF_FFFF_FFF8);
    check("wrap mem_addr0", bus.mem_addr, 64'hFFFF_FFFF_FFFF_FFF8);
    feed(64'h1, 0);
    tick(1);
    check("wrap mem_addr1", bus.mem_addr, 64'h0);
    feed(64'h3, 0);
    tick(1);
    check("wrap tc", bus.Transfer_complete, 1);
    check("wrap sys_addr", sys_addr, 64'h8);

    // Reset in the middle of a transfer.
    do_reset();
    kick(64'h6000);
    feed(64'h0000_9000_0100_0021, 0);
    check("t6 xfer_start", bus.xfer_start, 1);
    tick(1);
    #2 reset_n = 0;
    #1 check_zero("t6 async");
    tick(1);
    reset_n = 1;
    done_pulse();
    check("t6 done ignored mem_req", bus.mem_req, 0);
    check("t6 done ignored sys", sys_addr, 0);
    check("t6 done ignored sar", bus.ADMA_System_Address_Register, 0);
    check("t6 done ignored int", bus.DMA_Interrupt, 0);
    kick(64'h7000);
    check("t6 restart addr", bus.mem_addr, 64'h7000);
    check("t6 restart sys", sys_addr, 64'h7000);
    feed(64'h3, 0);
    tick(1);
    check("t6 restart tc", bus.Transfer_complete, 1);

    // Randomized tables against the model.
    do_reset();
    exp_es = 2'b00;
    for (int it = 0; it < 40; it++) begin
      logic [63:0] base;
      base = 64'($urandom_range(1, 32'h00FF_FFFF)) << 3;
      build_table(base);
      model_walk(base);
      run_walk(base);
      if (e_err != 0) exp_es = 2'b01;
      check("rnd nfetch", obs_fetch.size(), exp_fetch.size());
      for (int i = 0; i < obs_fetch.size() && i < exp_fetch.size(); i++)
        check("rnd fetch addr", obs_fetch[i], exp_fetch[i]);
      check("rnd nxfer", obs_xa.size(), exp_xa.size());
      for (int i = 0; i < obs_xa.size() && i < exp_xa.size(); i++) begin
        check("rnd xfer addr", obs_xa[i], exp_xa[i]);
        check("rnd xfer len", obs_xl[i], exp_xl[i]);
      end
      check("rnd sar count", o_sar, e_sar);
      check("rnd int count", o_int, e_int);
      check("rnd tc count", o_tc, e_tc);
      check("rnd err count", o_err, e_err);
      check("rnd sys_addr", sys_addr, e_ptr);
      check("rnd err_state", err_state, exp_es);
      check("rnd idle", bus.mem_req, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
